// File: rtl/vector_exec_wb.sv
// vector_exec_wb: single-instruction vector execute/writeback engine for an
// 8 x 256-bit vector register file. Reads both sources, snapshots them,
// computes LPC lanes per cycle into a result buffer, then issues one write.
// Optional feature: define VEXEC_SATURATE_EN to make ADD/SUB saturate per lane
// to the signed range instead of wrapping.
// All outputs are registered off the current state, so each output becomes
// visible one cycle after the state that decides it.
module vector_exec_wb #(
    parameter int unsigned LANE_W = 16,
    parameter int unsigned LPC    = 4
) (
    input  logic         clk,
    input  logic         Vreset,
    input  logic         Vstart,
    input  logic [1:0]   Vop,
    input  logic [2:0]   VsrcA,
    input  logic [2:0]   VsrcB,
    input  logic [2:0]   Vdst,
    input  logic [255:0] Va,
    input  logic [255:0] Vb,
    output logic [2:0]   VreadA,
    output logic [2:0]   VreadB,
    output logic [2:0]   VwrAddr,
    output logic [255:0] Vwrdata,
    output logic         VwrEn,
    output logic         VwrStart,
    output logic         Vbusy,
    output logic         Vdone
);

    localparam int unsigned NLANE = 256 / LANE_W;
    localparam int unsigned NCYC  = NLANE / LPC;
    localparam int unsigned CNT_W = (NCYC > 1) ? $clog2(NCYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCYC - 1);

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StCap,
        StExec,
        StWb,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [2:0]       dst_q, dst_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [255:0]     opa_q, opa_d;
    logic [255:0]     opb_q, opb_d;
    logic [255:0]     res_q, res_d;
    logic [2:0]       read_a_q, read_a_d;
    logic [2:0]       read_b_q, read_b_d;
    logic             wr_en_q, wr_en_d;
    logic [2:0]       wr_addr_q, wr_addr_d;
    logic [255:0]     wr_data_q, wr_data_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // One lane of the datapath; lanes never interact.
    function automatic logic [LANE_W-1:0] lane_op(input logic [1:0]        op,
                                                  input logic [LANE_W-1:0] a,
                                                  input logic [LANE_W-1:0] b);
        logic [LANE_W-1:0] r;
`ifdef VEXEC_SATURATE_EN
        logic [LANE_W:0] ext;
        ext = '0;
`endif
        r = '0;
        unique case (op)
`ifdef VEXEC_SATURATE_EN
            2'b00: ext = {a[LANE_W-1], a} + {b[LANE_W-1], b};
            2'b01: ext = {a[LANE_W-1], a} - {b[LANE_W-1], b};
`else
            2'b00: r = a + b;
            2'b01: r = a - b;
`endif
            2'b10: r = a & b;
            default: r = ($signed(a) > $signed(b)) ? a : b;
        endcase
`ifdef VEXEC_SATURATE_EN
        // Sign-extended sum: the top two bits differ exactly on signed overflow.
        if (op[1] == 1'b0) begin
            if (ext[LANE_W] != ext[LANE_W-1]) begin
                r = ext[LANE_W] ? {1'b1, {(LANE_W-1){1'b0}}} : {1'b0, {(LANE_W-1){1'b1}}};
            end else begin
                r = ext[LANE_W-1:0];
            end
        end
`endif
        return r;
    endfunction

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        dst_d     = dst_q;
        cnt_d     = cnt_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        res_d     = res_q;
        read_a_d  = read_a_q;
        read_b_d  = read_b_q;
        wr_en_d   = 1'b0;
        wr_addr_d = '0;
        wr_data_d = '0;
        busy_d    = busy_q;
        done_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (Vstart) begin
                    op_d     = Vop;
                    dst_d    = Vdst;
                    read_a_d = VsrcA;
                    read_b_d = VsrcB;
                    busy_d   = 1'b1;
                    state_d  = StRd;
                end
            end
            StRd: begin
                // Regfile samples the read addresses on this edge.
                state_d = StCap;
            end
            StCap: begin
                // Snapshot so later regfile read data cannot leak into the result.
                opa_d   = Va;
                opb_d   = Vb;
                cnt_d   = '0;
                state_d = StExec;
            end
            StExec: begin
                for (int unsigned j = 0; j < LPC; j++) begin
                    res_d[(32'(cnt_q) * LPC + j) * LANE_W +: LANE_W] =
                        lane_op(op_q,
                                opa_q[(32'(cnt_q) * LPC + j) * LANE_W +: LANE_W],
                                opb_q[(32'(cnt_q) * LPC + j) * LANE_W +: LANE_W]);
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = StWb;
                end
            end
            StWb: begin
                wr_en_d   = 1'b1;
                wr_addr_d = dst_q;
                wr_data_d = res_q;
                state_d   = StDone;
            end
            StDone: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers; reset aborts any op in flight without a write.
    always_ff @(posedge clk) begin
        if (Vreset) begin
            state_q   <= StIdle;
            op_q      <= '0;
            dst_q     <= '0;
            cnt_q     <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            res_q     <= '0;
            read_a_q  <= '0;
            read_b_q  <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            dst_q     <= dst_d;
            cnt_q     <= cnt_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            res_q     <= res_d;
            read_a_q  <= read_a_d;
            read_b_q  <= read_b_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign VreadA   = read_a_q;
    assign VreadB   = read_b_q;
    assign VwrAddr  = wr_addr_q;
    assign Vwrdata  = wr_data_q;
    assign VwrEn    = wr_en_q;
    assign VwrStart = wr_en_q;
    assign Vbusy    = busy_q;
    assign Vdone    = done_q;

endmodule

// File: tb/tb_vector_exec_wb.sv
// Bench for vector_exec_wb: register-file model plus a scoreboard. Stimulus
// pushes expected writes (computed lane by lane with integer arithmetic from a
// shadow copy of the registers); a negedge monitor pops and compares.
module tb_vector_exec_wb;

    logic         clk = 1'b0;
    logic         Vreset, Vstart;
    logic [1:0]   Vop;
    logic [2:0]   VsrcA, VsrcB, Vdst;
    logic [255:0] Va, Vb;
    logic [2:0]   VreadA, VreadB, VwrAddr;
    logic [255:0] Vwrdata;
    logic         VwrEn, VwrStart, Vbusy, Vdone;

    vector_exec_wb dut (
        .clk      (clk),
        .Vreset   (Vreset),
        .Vstart   (Vstart),
        .Vop      (Vop),
        .VsrcA    (VsrcA),
        .VsrcB    (VsrcB),
        .Vdst     (Vdst),
        .Va       (Va),
        .Vb       (Vb),
        .VreadA   (VreadA),
        .VreadB   (VreadB),
        .VwrAddr  (VwrAddr),
        .Vwrdata  (Vwrdata),
        .VwrEn    (VwrEn),
        .VwrStart (VwrStart),
        .Vbusy    (Vbusy),
        .Vdone    (Vdone)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Register file with registered reads; backdoor port for preloading.
    logic [255:0] rf [8];
    logic         bd_we = 1'b0;
    logic [2:0]   bd_addr = '0;
    logic [255:0] bd_data = '0;
    always @(posedge clk) begin
        if (VwrEn) rf[VwrAddr] <= Vwrdata;
        else if (bd_we) rf[bd_addr] <= bd_data;
        Va <= rf[VreadA];
        Vb <= rf[VreadB];
    end

    logic [255:0] mdl [8];

    typedef struct {
        logic [2:0]   addr;
        logic [255:0] data;
        int           acc;
    } exp_t;
    exp_t exp_q[$];
    int   done_q[$];

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Reference: per-lane integer arithmetic, then truncate (or clamp).
    function automatic logic [255:0] model(input logic [1:0] op, input logic [255:0] a,
                                           input logic [255:0] b);
        logic [255:0] r;
        logic [15:0]  la, lb;
        int sa, sb, s;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            la = a[i*16 +: 16];
            lb = b[i*16 +: 16];
            sa = int'($signed(la));
            sb = int'($signed(lb));
            case (op)
                2'd0: s = sa + sb;
                2'd1: s = sa - sb;
                2'd2: s = int'({16'd0, la & lb});
                default: s = (sa > sb) ? sa : sb;
            endcase
`ifdef VEXEC_SATURATE_EN
            if (op < 2'd2) begin
                if (s > 32767) s = 32767;
                if (s < -32768) s = -32768;
            end
`endif
            r[i*16 +: 16] = s[15:0];
        end
        return r;
    endfunction

    // Monitor: compare every write and done pulse against the scoreboard.
    always @(negedge clk) begin
        if (VwrEn) begin
            if (exp_q.size() == 0) begin
                check("wr_when_none_expected", 256'(VwrEn), 256'(0));
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("wr_addr", 256'(VwrAddr), 256'(e.addr));
                check("wr_data", Vwrdata, e.data);
                check("wr_start", 256'(VwrStart), 256'(1));
                check("wr_latency", 256'(cyc - e.acc), 256'(7));
            end
        end
        if (Vdone) begin
            if (done_q.size() == 0) begin
                check("done_when_none_expected", 256'(Vdone), 256'(0));
            end else begin
                int a;
                a = done_q.pop_front();
                check("done_latency", 256'(cyc - a), 256'(8));
                check("busy_low_at_done", 256'(Vbusy), 256'(0));
            end
        end
    end

    task automatic wait_idle();
        for (int k = 0; k < 40 && Vbusy; k++) @(negedge clk);
        check("idle_timeout", 256'(Vbusy), 256'(0));
    endtask

    task automatic load_reg(input logic [2:0] i, input logic [255:0] d);
        bd_we   = 1'b1;
        bd_addr = i;
        bd_data = d;
        mdl[i]  = d;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after accept.
    task automatic issue(input logic [1:0] op, input logic [2:0] a, input logic [2:0] b,
                         input logic [2:0] d, input bit expect_it, input bit noisy);
        logic [255:0] r;
        wait_idle();
        Vop = op; VsrcA = a; VsrcB = b; Vdst = d; Vstart = 1'b1;
        if (expect_it) begin
            r = model(op, mdl[a], mdl[b]);
            mdl[d] = r;
            exp_q.push_back('{addr: d, data: r, acc: cyc + 1});
            done_q.push_back(cyc + 1);
        end
        @(negedge clk);
        if (noisy) begin
            // Edges E1..E7 all see a request with scrambled fields.
            for (int k = 0; k < 7; k++) begin
                Vstart = 1'b1;
                Vop    = 2'($urandom);
                VsrcA  = 3'($urandom);
                VsrcB  = 3'($urandom);
                Vdst   = 3'($urandom);
                @(negedge clk);
            end
        end
        Vstart = 1'b0;
        Vop    = 2'($urandom);
        VsrcA  = 3'($urandom);
        VsrcB  = 3'($urandom);
        Vdst   = 3'($urandom);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_VreadA"}, 256'(VreadA), 256'(0));
        check({tag, "_VreadB"}, 256'(VreadB), 256'(0));
        check({tag, "_VwrAddr"}, 256'(VwrAddr), 256'(0));
        check({tag, "_Vwrdata"}, Vwrdata, 256'(0));
        check({tag, "_VwrEn"}, 256'(VwrEn), 256'(0));
        check({tag, "_VwrStart"}, 256'(VwrStart), 256'(0));
        check({tag, "_Vbusy"}, 256'(Vbusy), 256'(0));
        check({tag, "_Vdone"}, 256'(Vdone), 256'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        logic [255:0] t;
        Vreset = 1'b1; Vstart = 1'b0; Vop = '0; VsrcA = '0; VsrcB = '0; Vdst = '0;
        repeat (2) @(negedge clk);
        check_outputs_zero("reset");
        Vreset = 1'b0;
        for (int i = 0; i < 8; i++) load_reg(3'(i), rand256());

        // ADD of constant lanes.
        load_reg(3'd0, {16{16'h0003}});
        load_reg(3'd1, {16{16'h0005}});
        issue(2'd0, 3'd0, 3'd1, 3'd2, 1'b1, 1'b0);

        // SUB wrap / saturation corners.
        load_reg(3'd3, {16{16'h0000}});
        load_reg(3'd4, {16{16'h0001}});
        issue(2'd1, 3'd3, 3'd4, 3'd6, 1'b1, 1'b0);
        load_reg(3'd3, {{8{16'h7FFF}}, {8{16'h8000}}});
        issue(2'd1, 3'd3, 3'd4, 3'd6, 1'b1, 1'b0);
        issue(2'd0, 3'd3, 3'd4, 3'd7, 1'b1, 1'b0);

        // Signed MAX corners in lanes 0 and 1.
        t = rand256();
        t[15:0] = 16'hFFFF; t[31:16] = 16'h7000;
        load_reg(3'd0, t);
        t = rand256();
        t[15:0] = 16'h0001; t[31:16] = 16'h8000;
        load_reg(3'd1, t);
        issue(2'd3, 3'd0, 3'd1, 3'd7, 1'b1, 1'b0);

        // In-place AND, then a back-to-back read of the new value.
        load_reg(3'd1, {16{16'h00FF}});
        issue(2'd2, 3'd5, 3'd1, 3'd5, 1'b1, 1'b0);
        issue(2'd0, 3'd5, 3'd5, 3'd4, 1'b1, 1'b0);

        // Requests held high and fields scrambled while busy.
        for (int n = 0; n < 3; n++)
            issue(2'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 1'b1, 1'b1);

        // Abort during the second EXEC cycle.
        issue(2'd0, 3'd1, 3'd2, 3'd3, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        Vreset = 1'b1;
        @(negedge clk);
        Vreset = 1'b0;
        check_outputs_zero("abort");
        repeat (10) @(negedge clk);
        issue(2'd1, 3'd1, 3'd2, 3'd3, 1'b1, 1'b0);

        // Reset and start together: request is dropped.
        wait_idle();
        Vreset = 1'b1; Vstart = 1'b1;
        @(negedge clk);
        Vreset = 1'b0; Vstart = 1'b0;
        check("rst_start_busy0", 256'(Vbusy), 256'(0));
        @(negedge clk);
        check("rst_start_busy1", 256'(Vbusy), 256'(0));

        // Random traffic.
        for (int n = 0; n < 20; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                wait_idle();
                load_reg(3'($urandom), rand256());
            end
            issue(2'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 1'b1,
                  ($urandom_range(0, 4) == 0));
        end

        wait_idle();
        repeat (4) @(negedge clk);
        check("pending_writes", 256'(exp_q.size()), 256'(0));
        check("pending_dones", 256'(done_q.size()), 256'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
